// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state encoding and index helpers for the FFT stages.
`timescale 1ns/1ps
package fft_pkg;

    localparam int unsigned FFT_PTS  = 32;
    localparam int unsigned FFT_LOG2 = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fft_state_e;

    // Reverse the bit order of a 5-bit bin index.
    function automatic logic [FFT_LOG2-1:0] bitrev5(input logic [FFT_LOG2-1:0] idx);
        logic [FFT_LOG2-1:0] rev;
        rev = '0;
        for (int b = 0; b < int'(FFT_LOG2); b++) begin
            rev[FFT_LOG2-1-b] = idx[b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// fft_bitrev_idx: purely combinational 5-bit bit-reversal index remapper.
`timescale 1ns/1ps
module fft_bitrev_idx
    import fft_pkg::*;
(
    input  logic [FFT_LOG2-1:0] idx,
    output logic [FFT_LOG2-1:0] idx_rev_c
);

    // Map a storage index to its bit-reversed counterpart.
    always_comb begin
        idx_rev_c = bitrev5(idx);
    end

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a full 32-bin FFT frame in one cycle and streams it
// out one bin per beat over valid/ready. Define FFT_OUT_BITREV_EN to read the
// buffer in bit-reversed order so bins leave in natural frequency order.
`timescale 1ns/1ps
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic                  clk2,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FFT_PTS*N-1:0]  in_re,
    input  logic [FFT_PTS*N-1:0]  in_im,
    output logic                  load_ready,
    output logic [N-1:0]          out_re,
    output logic [N-1:0]          out_im,
    output logic [FFT_LOG2-1:0]   out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    // Q only documents the fixed-point format; reject a format with no integer bits.
    if (Q >= N) begin : g_bad_q
        $error("fft_out_serializer: Q must be smaller than N");
    end

    localparam logic [FFT_LOG2-1:0] LAST_IDX = FFT_LOG2'(FFT_PTS - 1);

    fft_state_e          state;
    fft_state_e          state_nxt;
    logic [FFT_LOG2-1:0] rd_cnt;
    logic [FFT_LOG2-1:0] rd_addr;
    logic [N-1:0]        buf_re [FFT_PTS];
    logic [N-1:0]        buf_im [FFT_PTS];
    logic                capture;
    logic                beat;

    assign capture = load && load_ready;
    assign beat    = out_valid && out_ready;

`ifdef FFT_OUT_BITREV_EN
    fft_bitrev_idx u_rd_map (
        .idx       (rd_cnt),
        .idx_rev_c (rd_addr)
    );
`else
    assign rd_addr = rd_cnt;
`endif

    // State register.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a capture always (re)starts a stream, the final beat ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) state_nxt = STREAM;
            end
            STREAM: begin
                if (capture)                              state_nxt = STREAM;
                else if (beat && (rd_cnt == LAST_IDX))    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: handshake flags decoded from registered state and out_ready.
    always_comb begin
        out_valid  = 1'b0;
        out_last   = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            STREAM: begin
                out_valid  = 1'b1;
                out_last   = (rd_cnt == LAST_IDX);
                load_ready = out_ready && (rd_cnt == LAST_IDX);
            end
            default: begin
                load_ready = 1'b1;
            end
        endcase
    end

    // Frame buffer and read counter; the counter holds on the final beat so
    // the outputs keep their last bin while idle.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            for (int k = 0; k < int'(FFT_PTS); k++) begin
                buf_re[k] <= '0;
                buf_im[k] <= '0;
            end
        end else if (capture) begin
            rd_cnt <= '0;
            for (int k = 0; k < int'(FFT_PTS); k++) begin
                buf_re[k] <= in_re[k*N +: N];
                buf_im[k] <= in_im[k*N +: N];
            end
        end else if (beat && (rd_cnt != LAST_IDX)) begin
            rd_cnt <= rd_cnt + FFT_LOG2'(1);
        end
    end

    assign out_re  = buf_re[rd_addr];
    assign out_im  = buf_im[rd_addr];
    assign out_idx = rd_cnt;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: randomized self-checking bench for fft_out_serializer.
// Honors FFT_OUT_BITREV_EN to pick the expected read order.
`timescale 1ns/1ps
module tb_fft_out_serializer;

    localparam int W   = 16;
    localparam int PTS = 32;

    logic              clk2 = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [PTS*W-1:0]  in_re = '0;
    logic [PTS*W-1:0]  in_im = '0;
    logic              load_ready;
    logic [W-1:0]      out_re;
    logic [W-1:0]      out_im;
    logic [4:0]        out_idx;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] cur_re [PTS];
    logic [W-1:0] cur_im [PTS];
    logic [W-1:0] nxt_re [PTS];
    logic [W-1:0] nxt_im [PTS];

    fft_out_serializer #(.N(W), .Q(8)) dut (
        .clk2       (clk2),
        .rst_n      (rst_n),
        .load       (load),
        .in_re      (in_re),
        .in_im      (in_im),
        .load_ready (load_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk2 = ~clk2;

    // Which input slot supplies output beat i.
    function automatic int slot_of(input int i);
`ifdef FFT_OUT_BITREV_EN
        int r;
        int v;
        r = 0;
        v = i;
        for (int b = 0; b < 5; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic fill_nxt_ramp(input int base);
        for (int k = 0; k < PTS; k++) begin
            nxt_re[k] = W'(base + k);
            nxt_im[k] = W'(-(base + k));
        end
    endtask

    task automatic fill_nxt_rand();
        for (int k = 0; k < PTS; k++) begin
            nxt_re[k] = W'($urandom);
            nxt_im[k] = W'($urandom);
        end
    endtask

    task automatic drive_nxt();
        for (int k = 0; k < PTS; k++) begin
            in_re[k*W +: W] = nxt_re[k];
            in_im[k*W +: W] = nxt_im[k];
        end
    endtask

    task automatic promote_nxt();
        for (int k = 0; k < PTS; k++) begin
            cur_re[k] = nxt_re[k];
            cur_im[k] = nxt_im[k];
        end
    endtask

    // Present nxt_* with load from IDLE; the capture happens on the coming edge.
    task automatic load_frame();
        @(negedge clk2);
        out_ready = 1'b0;
        drive_nxt();
        load = 1'b1;
        #1;
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready_idle: got %b want 1", load_ready);
        end
        promote_nxt();
    endtask

    // Consume the frame in cur_*, checking every beat. Optional: random ready,
    // reload nxt_* on the final beat, junk load at busy_at, reset at abort_at.
    task automatic stream_frame(input bit rand_ready, input bit reload_end,
                                input int busy_at, input int abort_at);
        int  pos;
        int  cyc;
        bit  stalled;
        logic [W-1:0] held_re;
        logic [W-1:0] held_im;
        pos = 0;
        cyc = 0;
        stalled = 1'b0;
        held_re = '0;
        held_im = '0;
        while (pos < PTS && cyc < 400) begin
            @(negedge clk2);
            cyc++;
            load = 1'b0;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pos == abort_at) begin
                rst_n = 1'b0;
                #1;
                total++;
                if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0) begin
                    bad++;
                    $display("FAIL async_reset: valid=%b re=%h im=%h want 0/0/0",
                             out_valid, out_re, out_im);
                end
                return;
            end
            if (pos == busy_at) begin
                for (int k = 0; k < PTS; k++) begin
                    in_re[k*W +: W] = W'($urandom);
                    in_im[k*W +: W] = W'($urandom);
                end
                load = 1'b1;
            end
            if (reload_end && pos == PTS - 1) begin
                out_ready = 1'b1;
                drive_nxt();
                load = 1'b1;
            end
            #1;
            total++;
            if (out_valid !== 1'b1 || out_idx !== 5'(pos) ||
                out_re !== cur_re[slot_of(pos)] || out_im !== cur_im[slot_of(pos)]) begin
                bad++;
                $display("FAIL beat%0d: valid=%b idx=%0d re=%h im=%h want 1 %0d %h %h",
                         pos, out_valid, out_idx, out_re, out_im, pos,
                         cur_re[slot_of(pos)], cur_im[slot_of(pos)]);
            end
            total++;
            if (out_last !== (pos == PTS - 1) ||
                load_ready !== (out_ready && pos == PTS - 1)) begin
                bad++;
                $display("FAIL flags%0d: last=%b load_ready=%b want %b %b", pos,
                         out_last, load_ready, (pos == PTS - 1), (out_ready && pos == PTS - 1));
            end
            if (stalled) begin
                total++;
                if (out_re !== held_re || out_im !== held_im) begin
                    bad++;
                    $display("FAIL stall_hold%0d: re=%h im=%h want %h %h",
                             pos, out_re, out_im, held_re, held_im);
                end
            end
            stalled = !out_ready;
            held_re = out_re;
            held_im = out_im;
            if (out_ready) pos++;
        end
        total++;
        if (pos < PTS) begin
            bad++;
            $display("FAIL stream_timeout: beats=%0d want %0d", pos, PTS);
        end
        if (reload_end) promote_nxt();
    endtask

    // After a completed frame: idle flags, last bin held.
    task automatic check_idle(input string tag);
        @(negedge clk2);
        load = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || load_ready !== 1'b1 ||
            out_idx !== 5'd31 || out_re !== cur_re[slot_of(31)] || out_im !== cur_im[slot_of(31)]) begin
            bad++;
            $display("FAIL idle_%s: valid=%b last=%b lr=%b idx=%0d re=%h want 0 0 1 31 %h",
                     tag, out_valid, out_last, load_ready, out_idx, out_re, cur_re[slot_of(31)]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load = 1'b1;
        for (int k = 0; k < PTS; k++) begin
            in_re[k*W +: W] = W'(k + 7);
            in_im[k*W +: W] = W'(k + 9);
        end
        repeat (3) @(negedge clk2);
        #1;
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1 || out_re !== '0 ||
            out_im !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b lr=%b re=%h im=%h idx=%0d want 0 1 0 0 0",
                     out_valid, load_ready, out_re, out_im, out_idx);
        end
        @(negedge clk2);
        load = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk2);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_re !== '0) begin
            bad++;
            $display("FAIL reset_release: valid=%b re=%h want 0 0", out_valid, out_re);
        end
    endtask

    task automatic test_single_frame();
        fill_nxt_ramp(0);
        load_frame();
        stream_frame(1'b0, 1'b0, -1, -1);
        check_idle("single");
    endtask

    task automatic test_stall();
        fill_nxt_rand();
        load_frame();
        stream_frame(1'b1, 1'b0, -1, -1);
        check_idle("stall");
    endtask

    task automatic test_back_to_back();
        fill_nxt_ramp(0);
        load_frame();
        fill_nxt_ramp(100);
        stream_frame(1'b0, 1'b1, -1, -1);
        fill_nxt_rand();
        stream_frame(1'b1, 1'b1, -1, -1);
        stream_frame(1'b0, 1'b0, -1, -1);
        check_idle("b2b");
    endtask

    task automatic test_load_busy();
        fill_nxt_rand();
        load_frame();
        stream_frame(1'b1, 1'b0, 10, -1);
        check_idle("busy");
    endtask

    task automatic test_reset_mid();
        fill_nxt_rand();
        load_frame();
        stream_frame(1'b0, 1'b0, -1, 17);
        @(negedge clk2);
        rst_n = 1'b1;
        load = 1'b0;
        repeat (3) @(negedge clk2);
        #1;
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1 || out_idx !== '0) begin
            bad++;
            $display("FAIL post_reset_idle: valid=%b lr=%b idx=%0d want 0 1 0",
                     out_valid, load_ready, out_idx);
        end
        fill_nxt_rand();
        load_frame();
        stream_frame(1'b0, 1'b0, -1, -1);
        check_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_load_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
